// File: rtl/sam_out_packetizer_if.sv
// Stream bundle between the SAM core output, the packetizer and the DMA.
// The master side feeds words, flush and m_ready; the slave side is the packetizer.
interface sam_out_packetizer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              flush;

  modport master (
    output in_data, in_valid, m_ready, flush,
    input  in_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  in_data, in_valid, m_ready, flush,
    output in_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/sam_out_packetizer.sv
// Buffers SAM core output words in a small FIFO and re-emits them as framed
// packets with m_last every PKT_LEN words, or early on a flush request.
module sam_out_packetizer #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int PKT_LEN    = 256
) (
  input  logic                clk,
  input  logic                rstn,
  sam_out_packetizer_if.slave s,
  output logic [15:0]         pkt_count
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW       = AW + 1;
  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [15:0]   out_cnt_reg, out_cnt_next;
  logic [15:0]   pkt_count_reg, pkt_count_next;
  logic          flush_pend_reg, flush_pend_next;
  logic          run_reg;

  logic full, pkt_end, cnt_one, cnt_two_plus;
  logic push, pop;

  always_comb begin
    full         = (count_reg == CW'(FIFO_DEPTH));
    pkt_end      = (out_cnt_reg == LAST_IDX);
    cnt_one      = (count_reg == CW'(1));
    cnt_two_plus = (count_reg >= CW'(2));

    // run_reg keeps the input closed for the first cycle after reset.
    s.in_ready = rstn && run_reg && !full && !flush_pend_reg;

    // Keep the last buffered word back unless it may close the packet,
    // so a later flush always has a word to carry m_last.
    s.m_valid  = rstn && (cnt_two_plus || (cnt_one && (pkt_end || flush_pend_reg)));
    s.m_last   = s.m_valid && (pkt_end || (flush_pend_reg && cnt_one));
    s.m_data   = mem[rd_ptr_reg];

    push = s.in_valid && s.in_ready;
    pop  = s.m_valid && s.m_ready;

    wr_ptr_next    = push ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next    = pop  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    count_next     = count_reg + CW'(push) - CW'(pop);
    out_cnt_next   = out_cnt_reg;
    pkt_count_next = pkt_count_reg;
    if (pop && s.m_last) begin
      out_cnt_next   = '0;
      pkt_count_next = pkt_count_reg + 16'd1;
    end else if (pop) begin
      out_cnt_next   = out_cnt_reg + 16'd1;
    end

    // A pending flush lasts until the buffer has fully drained; a flush that
    // would leave nothing buffered opens no packet.
    flush_pend_next = (flush_pend_reg || s.flush) && (count_next != '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      out_cnt_reg    <= '0;
      pkt_count_reg  <= '0;
      flush_pend_reg <= 1'b0;
      run_reg        <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      out_cnt_reg    <= out_cnt_next;
      pkt_count_reg  <= pkt_count_next;
      flush_pend_reg <= flush_pend_next;
      run_reg        <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s.in_data;
    end
  end

  assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_sam_out_packetizer.sv
// Scoreboard bench for sam_out_packetizer with PKT_LEN=4: accepted words are
// queued with their expected m_last, and a monitor checks every output handshake.
module tb_sam_out_packetizer;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int PKT_LEN = 4;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] pkt_count;
  logic        rand_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t        exp_q[$];
  int          pos = 0;
  logic [15:0] exp_pkts = '0;

  sam_out_packetizer_if #(.DATA_W(DATA_W)) bus ();

  sam_out_packetizer #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .PKT_LEN(PKT_LEN)
  ) dut (
    .clk(clk), .rstn(rstn), .s(bus.slave), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: accepted words and flush pulses, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      exp_q.delete();
      pos = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        e.d    = bus.in_data;
        e.last = (pos == PKT_LEN - 1);
        pos    = e.last ? 0 : pos + 1;
        exp_q.push_back(e);
      end
      if (bus.flush && exp_q.size() > 0) begin
        exp_q[exp_q.size() - 1].last = 1'b1;
        pos = 0;
      end
    end
  end

  // Monitor: compare each output handshake against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      exp_pkts = '0;
    end else if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", bus.m_data, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("m_data", bus.m_data, e.d);
        check("m_last", {31'd0, bus.m_last}, {31'd0, e.last});
        $display("out data=%0h last=%0b", bus.m_data, bus.m_last);
        if (e.last) exp_pkts = exp_pkts + 16'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      bus.m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      ok = bus.in_ready;
      step();
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", d, 32'hFFFF_FFFF);
    else $display("in  data=%0h", d);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    for (t = 0; t < budget; t++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    rstn         = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.m_ready  = 1'b1;
    bus.flush    = 1'b0;
    repeat (3) step();
    check("rst_in_ready", {31'd0, bus.in_ready}, 0);
    check("rst_m_valid", {31'd0, bus.m_valid}, 0);
    check("rst_m_last", {31'd0, bus.m_last}, 0);
    check("rst_pkt_count", {16'd0, pkt_count}, 0);
    rstn = 1'b1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 0);
    step();

    // Two full packets of 4.
    for (int i = 0; i < 8; i++) send(i);
    drain(100);
    check("pkt_count_two", {16'd0, pkt_count}, 2);

    // Partial packet: last word held until flush.
    for (int i = 0; i < 3; i++) send(100 + i);
    repeat (4) step();
    check("hold_m_valid", {31'd0, bus.m_valid}, 0);
    check("hold_in_ready", {31'd0, bus.in_ready}, 1);
    check("hold_left", exp_q.size(), 1);
    pulse_flush();
    check("flush_in_ready", {31'd0, bus.in_ready}, 0);
    check("flush_m_valid", {31'd0, bus.m_valid}, 1);
    check("flush_m_last", {31'd0, bus.m_last}, 1);
    check("flush_m_data", bus.m_data, 102);
    step();
    check("flush_pkt_count", {16'd0, pkt_count}, 3);
    check("flush_in_ready_back", {31'd0, bus.in_ready}, 1);
    check("flush_m_valid_off", {31'd0, bus.m_valid}, 0);

    // Back-pressure: fill the FIFO, outputs must stay stable.
    bus.m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(200 + i);
    bus.in_data  = 216;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("full_in_ready", {31'd0, bus.in_ready}, 0);
      check("full_m_valid", {31'd0, bus.m_valid}, 1);
      check("full_m_data", bus.m_data, 200);
      step();
    end
    bus.in_valid = 1'b0;
    bus.m_ready  = 1'b1;
    for (int i = 16; i < 20; i++) send(200 + i);
    drain(100);
    check("bp_pkt_count", {16'd0, pkt_count}, 8);

    // Flush with empty FIFO is ignored.
    pulse_flush();
    for (int i = 0; i < 3; i++) begin
      check("eflush_m_valid", {31'd0, bus.m_valid}, 0);
      check("eflush_in_ready", {31'd0, bus.in_ready}, 1);
      step();
    end
    check("eflush_pkt_count", {16'd0, pkt_count}, 8);

    // Reset mid-packet drops the partial packet.
    send(300);
    send(301);
    repeat (2) step();
    rstn = 1'b0;
    step();
    check("mrst_in_ready", {31'd0, bus.in_ready}, 0);
    check("mrst_m_valid", {31'd0, bus.m_valid}, 0);
    check("mrst_m_last", {31'd0, bus.m_last}, 0);
    check("mrst_pkt_count", {16'd0, pkt_count}, 0);
    rstn = 1'b1;
    check("mrst_in_ready_after", {31'd0, bus.in_ready}, 0);
    step();
    for (int i = 0; i < 4; i++) send(400 + i);
    drain(100);
    check("mrst_pkt_count_one", {16'd0, pkt_count}, 1);

    // Flush in the same cycle as an accepted word: that word closes the packet.
    send(500);
    check("cflush_ready", {31'd0, bus.in_ready}, 1);
    bus.in_data  = 501;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    drain(100);
    check("cflush_pkt_count", {16'd0, pkt_count}, 2);

    // Random back-pressure and input gaps with occasional flushes.
    rand_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send(1000 + i);
      if (i % 37 == 36) pulse_flush();
    end
    rand_en = 1'b0;
    step();
    bus.m_ready = 1'b1;
    pulse_flush();
    drain(3000);
    check("rand_pkt_count", {16'd0, pkt_count}, {16'd0, exp_pkts});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
